// File: rtl/misc_v_pipe_pkg.sv
// misc_v_pipe_pkg: shared pipeline defaults and control-bundle field offsets
// Control bundle layout (LSB first): RegWrite, ALUSrc, ALUOP[2:0], MemWrite, MemRead, RegStore, spare.
package misc_v_pipe_pkg;
    localparam int DEF_CTRL_W   = 9;
    localparam int DEF_DATA_W   = 16;
    localparam int RW_BIT       = 0;
    localparam int ALUSRC_BIT   = 1;
    localparam int ALUOP_LSB    = 2;
    localparam int ALUOP_W      = 3;
    localparam int MEMW_BIT     = 5;
    localparam int MEMR_BIT     = 6;
    localparam int REGSTORE_BIT = 7;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one {valid, ctrl, data} pipeline entry with load, clear and sync reset
// Ports: CLK, Reset (sync, active-high); load captures ctrl_d/data_d and sets valid;
// clear drops valid (payload kept, clear wins over load); valid/ctrl/data are the held entry.
module pipe_entry_reg
    import misc_v_pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DW     = DEF_DATA_W * 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DW-1:0]     data_d,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DW-1:0]     data
);
    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ctrl_d;
            data  <= data_d;
        end
    end
endmodule

// File: rtl/ex_mem_pipe_buf.sv
// ex_mem_pipe_buf: EX/MEM pipeline register with valid/ready handshake, 2-entry skid, flush and stall counter
// Ports: CLK, Reset (sync, active-high); in_valid/in_ready/in_ctrl/in_data from EX;
// flush empties the buffer; out_valid/out_ready/out_ctrl/out_data toward MEM;
// stall_cnt saturates counting cycles with out_valid & !out_ready.
module ex_mem_pipe_buf
    import misc_v_pipe_pkg::*;
#(
    parameter int DATA_W              = DEF_DATA_W,
    parameter int NDATA               = 3,
    parameter int CTRL_W              = DEF_CTRL_W,
    parameter int ZERO_DATA_ON_BUBBLE = 1,
    parameter int STALL_CNT_W         = 16
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [DATA_W*NDATA-1:0] in_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [DATA_W*NDATA-1:0] out_data,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);
    localparam int DW = DATA_W * NDATA;
    logic              main_v, skid_v, accept, drain;
    logic              main_load, main_clear, skid_load, skid_clear, next_full;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DW-1:0]     main_data, skid_data, main_data_d;
    always_comb begin
        accept      = in_valid & in_ready;
        drain       = main_v & out_ready;
        // Main refills from skid when one is held, otherwise straight from EX.
        main_ctrl_d = skid_v ? skid_ctrl : in_ctrl;
        main_data_d = skid_v ? skid_data : in_data;
        main_load   = !flush & (main_v ? drain & (skid_v | accept) : accept);
        main_clear  = flush | (drain & !skid_v & !accept);
        skid_load   = !flush & main_v & !skid_v & accept & !drain;
        skid_clear  = flush | (skid_v & drain);
        next_full   = !flush & (skid_v ? !drain : main_v & accept & !drain);
        out_valid   = main_v;
        out_ctrl    = main_v ? main_ctrl : '0;
        out_data    = (ZERO_DATA_ON_BUBBLE != 0 && !main_v) ? '0 : main_data;
    end
    pipe_entry_reg #(.CTRL_W(CTRL_W), .DW(DW)) u_main (
        .CLK(CLK), .Reset(Reset), .load(main_load), .clear(main_clear),
        .ctrl_d(main_ctrl_d), .data_d(main_data_d),
        .valid(main_v), .ctrl(main_ctrl), .data(main_data)
    );
    pipe_entry_reg #(.CTRL_W(CTRL_W), .DW(DW)) u_skid (
        .CLK(CLK), .Reset(Reset), .load(skid_load), .clear(skid_clear),
        .ctrl_d(in_ctrl), .data_d(in_data),
        .valid(skid_v), .ctrl(skid_ctrl), .data(skid_data)
    );
    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            in_ready  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            in_ready <= !next_full;
            if (main_v && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ex_mem_pipe_buf.sv
// tb_ex_mem_pipe_buf: randomized scoreboard bench for ex_mem_pipe_buf against a queue model
module tb_ex_mem_pipe_buf;
    localparam int CW = 9;
    localparam int DW = 16;
    localparam int ND = 3;
    localparam int W  = DW * ND;
    typedef struct {
        logic [CW-1:0] c;
        logic [W-1:0]  d;
    } ent_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, s_in_ready, s_out_valid;
    logic [CW-1:0] out_ctrl, s_out_ctrl;
    logic [W-1:0]  out_data, s_out_data;
    logic [15:0]   stall_cnt;
    logic [3:0]    s_stall_cnt;
    ent_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cnt16 = 0;
    int  cnt4 = 0;
    bit  armed = 1'b0;
    bit  last_rst = 1'b1;
    bit  rdy_m = 1'b0;
    always #5 clk = ~clk;
    ex_mem_pipe_buf u_dut (
        .CLK(clk), .Reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .stall_cnt(stall_cnt)
    );
    ex_mem_pipe_buf #(.ZERO_DATA_ON_BUBBLE(0), .STALL_CNT_W(4)) u_sat (
        .CLK(clk), .Reset(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .stall_cnt(s_stall_cnt)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Monitor: compares what the DUTs present against the model, then retires drained heads.
    always @(negedge clk) begin
        rdy_m = !last_rst && q.size() < 2;
        if (armed) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, rdy_m);
            chk("stall_cnt", stall_cnt, cnt16);
            chk("sat_out_valid", s_out_valid, q.size() > 0);
            chk("sat_in_ready", s_in_ready, rdy_m);
            chk("sat_stall_cnt", s_stall_cnt, cnt4);
            if (q.size() > 0) begin
                chk("out_ctrl", out_ctrl, q[0].c);
                chk("out_data", out_data, q[0].d);
                chk("sat_out_ctrl", s_out_ctrl, q[0].c);
                chk("sat_out_data", s_out_data, q[0].d);
            end else begin
                chk("bubble_ctrl", out_ctrl, 0);
                chk("bubble_data", out_data, 0);
                chk("sat_bubble_ctrl", s_out_ctrl, 0);
            end
        end
        if (rst) begin
            cnt16 = 0;
            cnt4  = 0;
        end else if (q.size() > 0 && !out_ready) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        if (q.size() > 0 && out_ready) void'(q.pop_front());
    end
    // Drive one cycle of inputs and push accepted entries into the scoreboard.
    task automatic cyc(input bit r, input bit iv, input logic [CW-1:0] cv,
                       input logic [W-1:0] dv, input bit fl, input bit ordy);
        rst = r; in_valid = iv; in_ctrl = cv; in_data = dv; flush = fl; out_ready = ordy;
        @(negedge clk);
        #1;
        if (r) q.delete();
        else begin
            if (iv && rdy_m) q.push_back('{cv, dv});
            if (fl) q.delete();
        end
        last_rst = r;
        if (r) armed = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input bit ordy);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, ordy);
    endtask
    function automatic logic [W-1:0] w0(input logic [15:0] x);
        return {32'h0, x};
    endfunction
    initial begin
        cyc(1'b1, 1'b1, 9'h1FF, '1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 9'h1FF, '1, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, CW'(i + 1), w0(16'h1000 + 16'(i)), 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b0, 1'b1, 9'h0AA, w0(16'hAAAA), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9'h0BB, w0(16'hBBBB), 1'b0, 1'b0);
        repeat (5) idle(1'b0);
        repeat (3) idle(1'b1);
        cyc(1'b0, 1'b1, 9'h0AA, w0(16'hAAAA), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9'h0BB, w0(16'hBBBB), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9'h0CC, w0(16'hCCCC), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b0, 1'b1, 9'h111, w0(16'h1111), 1'b0, 1'b0);
        repeat (20) idle(1'b0);
        idle(1'b1);
        cyc(1'b0, 1'b1, 9'h0AA, w0(16'hAAAA), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9'h0BB, w0(16'hBBBB), 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9'h0DD, w0(16'hDDDD), 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
                CW'($urandom_range(0, 511)), {$urandom, $urandom},
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        idle(1'b1);
        idle(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_mem_pipe_buf.md
Name: ex_mem_pipe_buf

Overview:
- Parametrised successor to the fixed 16-bit EX/MEM latch: a generic pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion.
- Decouples EX from MEM so that a MEM-side stall does not combinationally back-propagate through `in_ready`.
- Carries one control word and NDATA data words per entry.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 16, width of each data word (ALU result, 3rd arg, Rd value).
- NDATA, 3, number of data words per entry.
- CTRL_W, 9, control-bundle width (RegWrite, ALUSrc, ALUOP[2:0], MemWrite, MemRead, RegStore, spare).
- ZERO_DATA_ON_BUBBLE, 1, when 1 `out_data` is forced to 0 whenever `out_valid`=0.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX presents a valid entry.
- in_ready  out  1  buffer can accept; registered, no combinational path from `out_ready`.
- in_ctrl  in  CTRL_W  control bundle from EX.
- in_data  in  DATA_W*NDATA  data words; word k at bits [k*DATA_W +: DATA_W].
- flush  in  1  discard all held entries (branch mispredict / exception).
- out_valid  out  1  head entry valid toward MEM.
- out_ready  in  1  MEM accepts the head entry this cycle.
- out_ctrl  out  CTRL_W  head control; all-zero when `out_valid`=0.
- out_data  out  DATA_W*NDATA  head data; see ZERO_DATA_ON_BUBBLE.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

Behaviour:
- **Storage.** Main entry (head) and skid entry, each holding {valid, ctrl, data}.
- **State** is derived from the valid bits: EMPTY (none valid), ONE (main only), FULL (main + skid). Skid valid never occurs without main valid.
- **Handshakes.**
  - accept = `in_valid` & `in_ready`.
  - drain = `out_valid` & `out_ready`.
- **Transitions** (no flush):
  - EMPTY: accept → ONE, entry loaded into main.
  - ONE:
    - accept & drain → ONE, main replaced by input.
    - accept & !drain → FULL, input goes to skid.
    - !accept & drain → EMPTY.
    - otherwise hold.
  - FULL:
    - drain → ONE, skid moves to main, skid cleared.
    - otherwise hold.
    - No accept is possible, since `in_ready`=0.
- **in_ready.** Registered. Next value = 1 unless next state is FULL. Equivalently, `in_ready`=1 in EMPTY/ONE and 0 in FULL.
- **Latency.** 1 cycle: an entry accepted at edge N is on `out_*` after edge N. Throughput is 1 entry/cycle when `out_ready` is held 1.
- **Order.** Strict FIFO; an entry is never dropped or duplicated except on flush/reset.
- **Flush.**
  - Priority: flush > accept/drain in the same cycle.
  - Both valid bits clear at the next edge, and an input offered that cycle is discarded.
  - `in_ready`=1 the next cycle.
  - A drain coinciding with flush is still counted by MEM. The consumer treats the flush cycle's head as squashed; the block itself just empties.
- **Bubble.** When `out_valid`=0, `out_ctrl`=0, so RegWrite/MemWrite/MemRead are deasserted. `out_data`=0 if ZERO_DATA_ON_BUBBLE=1, otherwise stale.
- **stall_cnt.** Increments by 1 each cycle with `out_valid` & !`out_ready`. It saturates at all-ones (no wrap), is unaffected by flush, and is cleared only by Reset.
- **Reset** (synchronous, dominant over everything, including mid-stall or while FULL):
  - Both entries invalid, ctrl/data registers 0.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0.
  - `in_ready`=0 while Reset is high, then 1 on the first cycle after Reset deasserts.
- **No X on outputs.** All registers are reset, so outputs are never X after the first reset edge.

Decomposition:
- Shared package `misc_v_pipe_pkg`:
  - Control-bundle field offsets (RW_BIT, ALUSRC_BIT, ALUOP_LSB/ALUOP_W, MEMW_BIT, MEMR_BIT, REGSTORE_BIT).
  - Default CTRL_W=9 and DATA_W=16.
- One natural sub-module: `pipe_entry_reg`, a single {valid, ctrl, data} register with load, clear, and synchronous reset, instantiated twice (main, skid).
- Handshake/state logic stays in the top.

Test Plan:
- **Reset/bubble:** Reset=1 for 2 cycles with `in_valid`=1 and `in_ctrl`=9'h1FF → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=0; after release `in_ready`=1, `stall_cnt`=0.
- **Streaming:** `out_ready`=1; send ctrl 9'h001..9'h005 with data word0 = 16'h1000..16'h1004 on consecutive cycles → each appears exactly 1 cycle later in order, `in_ready` stays 1, `stall_cnt`=0.
- **Backpressure/skid:** `out_ready`=0, send A (16'hAAAA) then B (16'hBBBB) → after B, `in_ready`=0, `out_data`=A. Hold 5 cycles → `stall_cnt`=5 (plus the cycle before skid fill). Raise `out_ready` → A then B delivered, `in_ready` returns 1 the cycle after A drains.
- **Flush while FULL:** buffer holds A, B; assert flush with `in_valid`=1 carrying C → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, C never appears.
- **Stall counter saturation:** with STALL_CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt`=4'hF and stays there.
- **Reset mid-operation:** FULL with A, B and `out_ready`=0; pulse Reset for 1 cycle → next cycle all outputs 0 and `stall_cnt`=0; the following cycle `in_ready`=1 and a new entry D flows through with 1-cycle latency.
